// File: rtl/ram_init_ctrl.sv
// ram_init_ctrl: clears or pattern-fills external RAM with back-to-back AXI4 INCR write bursts
// before the core is released; reports completion and any bad write response.
module ram_init_ctrl #(
  parameter int                   ID_WIDTH   = 6,
  parameter logic [31:0]          MEM_SIZE   = 32'h10000,
  parameter logic [31:0]          BASE_ADDR  = 32'h0,
  parameter int                   BURST_LEN  = 16,
  parameter logic [63:0]          FILL_DATA  = 64'h0,
  parameter bit                   AUTO_START = 1'b1,
  parameter logic [ID_WIDTH-1:0]  TX_ID      = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_init_done,
  output logic                o_init_error,
  output logic [ID_WIDTH-1:0] o_awid,
  output logic [31:0]         o_awaddr,
  output logic [7:0]          o_awlen,
  output logic [2:0]          o_awsize,
  output logic [1:0]          o_awburst,
  output logic                o_awvalid,
  input  logic                i_awready,
  output logic [63:0]         o_wdata,
  output logic [7:0]          o_wstrb,
  output logic                o_wlast,
  output logic                o_wvalid,
  input  logic                i_wready,
  input  logic [ID_WIDTH-1:0] i_bid,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready
);
  localparam logic [31:0] STEP       = 32'(8 * BURST_LEN);
  localparam logic [31:0] LAST_BURST = MEM_SIZE / STEP - 32'd1;
  localparam logic [7:0]  LAST_BEAT  = 8'(BURST_LEN - 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_burst_cnt;
  logic [7:0]  r_beat_cnt;
  logic        r_error, r_kick, r_kicked;
  logic        w_go;

  // r_kick is a single-cycle start request on the first cycle after reset release
  assign w_go = (r_state == IDLE || r_state == DONE) && (i_start || r_kick);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: w_next = w_go ? ADDR : r_state;
      ADDR:       w_next = i_awready ? DATA : ADDR;
      DATA:       w_next = (i_wready && r_beat_cnt == LAST_BEAT) ? RESP : DATA;
      RESP:       w_next = !i_bvalid ? RESP : (r_burst_cnt == LAST_BURST) ? DONE : ADDR;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= BASE_ADDR;
      r_burst_cnt <= '0;
      r_beat_cnt  <= '0;
      r_error     <= 1'b0;
      r_kick      <= 1'b0;
      r_kicked    <= 1'b0;
    end else begin
      r_kicked <= 1'b1;
      r_kick   <= AUTO_START && !r_kicked;
      if (w_go) begin
        r_addr      <= BASE_ADDR;
        r_burst_cnt <= '0;
        r_error     <= 1'b0;
      end
      if (r_state == ADDR && i_awready) r_beat_cnt <= '0;
      if (r_state == DATA && i_wready) r_beat_cnt <= r_beat_cnt + 8'd1;
      if (r_state == RESP && i_bvalid) begin
        r_error     <= r_error || (i_bresp != 2'b00) || (i_bid != TX_ID);
        r_addr      <= r_addr + STEP;
        r_burst_cnt <= r_burst_cnt + 32'd1;
      end
    end
  end

  assign o_busy       = r_state == ADDR || r_state == DATA || r_state == RESP;
  assign o_init_done  = r_state == DONE;
  assign o_init_error = r_error;
  assign o_awid       = TX_ID;
  assign o_awaddr     = r_addr;
  assign o_awlen      = LAST_BEAT;
  assign o_awsize     = 3'd3;
  assign o_awburst    = 2'b01;
  assign o_awvalid    = r_state == ADDR;
  assign o_wdata      = FILL_DATA;
  assign o_wstrb      = 8'hFF;
  assign o_wlast      = r_state == DATA && r_beat_cnt == LAST_BEAT;
  assign o_wvalid     = r_state == DATA;
  assign o_bready     = r_state == RESP;
endmodule

// File: tb/tb_ram_init_ctrl.sv
// tb_ram_init_ctrl: random-stall AXI write slave plus scoreboard of addresses, beats and memory
// contents for ram_init_ctrl.
module tb_ram_init_ctrl;
  localparam int          BL   = 4;
  localparam logic [31:0] MS   = 32'd256;
  localparam logic [31:0] BASE = 32'h0;
  localparam logic [63:0] FILL = 64'hDEAD_BEEF_0123_4567;
  localparam logic [5:0]  TXID = 6'd5;
  localparam int          NB   = MS / (8 * BL);
  localparam int          NW   = MS / 8;

  logic        clk = 0, rst_n = 0, i_start = 0;
  logic        o_busy, o_init_done, o_init_error;
  logic [5:0]  o_awid, i_bid = '0;
  logic [31:0] o_awaddr;
  logic [7:0]  o_awlen, o_wstrb;
  logic [2:0]  o_awsize;
  logic [1:0]  o_awburst, i_bresp = '0;
  logic        o_awvalid, i_awready = 0, o_wlast, o_wvalid, i_wready = 0, i_bvalid = 0, o_bready;
  logic [63:0] o_wdata;

  ram_init_ctrl #(.ID_WIDTH(6), .MEM_SIZE(MS), .BASE_ADDR(BASE), .BURST_LEN(BL),
                  .FILL_DATA(FILL), .AUTO_START(1'b1), .TX_ID(TXID)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .o_busy(o_busy), .o_init_done(o_init_done),
    .o_init_error(o_init_error), .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen),
    .o_awsize(o_awsize), .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
    .i_wready(i_wready), .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
  );

  always #5 clk = ~clk;

  int          errors = 0, checks = 0;
  logic [31:0] aw_q[$];
  logic [63:0] mem[NW];
  int          beats, len_bad, wlast_bad, stable_bad, order_bad, post_bad, first_cyc, done_cyc;
  bit          got_done;

  task automatic run_fill(input bit stall, input int err_b, input int bad_b, input bit poke,
                          input int rst_b, output bit got_rst);
    logic [31:0] cur, pa;
    bit          pl, paw, pw, aw_ok, b_pend;
    int          beat, b_idx, cyc, pokes, idx;
    cur = '0; pa = '0; pl = 0; paw = 0; pw = 0; aw_ok = 0; b_pend = 0;
    beat = 0; b_idx = 0; cyc = 0; pokes = 0;
    aw_q.delete();
    for (int i = 0; i < NW; i++) mem[i] = '0;
    beats = 0; len_bad = 0; wlast_bad = 0; stable_bad = 0; order_bad = 0; post_bad = 0;
    first_cyc = -1; done_cyc = -1; got_done = 0; got_rst = 0;
    while (!got_done && cyc < 5000) begin
      @(negedge clk);
      if (paw && (o_awvalid !== 1'b1 || o_awaddr !== pa)) stable_bad++;
      if (pw && (o_wvalid !== 1'b1 || o_wlast !== pl || o_wdata !== FILL)) stable_bad++;
      if (o_init_done === 1'b1) begin
        got_done = 1;
        done_cyc = cyc;
      end else begin
        if (o_awvalid && first_cyc < 0) first_cyc = cyc;
        if (o_wvalid && !aw_ok) order_bad++;
        if (o_awvalid && (aw_ok || b_pend)) order_bad++;
        if (rst_b >= 0 && o_wvalid && aw_q.size() == rst_b + 1 && beat == 1) begin
          #2 rst_n = 0;
          #1 got_rst = 1;
          return;
        end
        i_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        i_wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        i_bvalid  = b_pend && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
        i_bresp   = (b_idx == err_b) ? 2'b10 : 2'b00;
        i_bid     = (b_idx == bad_b) ? (TXID ^ 6'd1) : TXID;
        i_start   = poke && o_wvalid && pokes < 3;
        if (i_start) pokes++;
        paw = o_awvalid && !i_awready; pa = o_awaddr;
        pw  = o_wvalid && !i_wready;   pl = o_wlast;
        if (o_awvalid && i_awready) begin
          aw_q.push_back(o_awaddr);
          if (o_awlen !== 8'(BL - 1) || o_awsize !== 3'd3 || o_awburst !== 2'b01 || o_awid !== TXID)
            len_bad++;
          cur = o_awaddr; beat = 0; aw_ok = 1;
        end
        if (o_wvalid && i_wready) begin
          if (o_wstrb !== 8'hFF || o_wlast !== (beat == BL - 1)) wlast_bad++;
          idx = int'((cur - BASE) / 8) + beat;
          if (idx >= 0 && idx < NW) mem[idx] = o_wdata;
          beat++; beats++;
          if (o_wlast) begin aw_ok = 0; b_pend = 1; end
        end
        if (o_bready && i_bvalid) begin b_pend = 0; b_idx++; end
      end
      cyc++;
    end
    i_awready = 0; i_wready = 0; i_bvalid = 0; i_start = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_init_done !== 1'b1 || o_busy !== 1'b0 || o_awvalid !== 1'b0) post_bad++;
    end
  endtask

  task automatic check_fill(input string tag, input bit exp_err);
    int bad_addr, bad_mem;
    bad_addr = 0; bad_mem = 0;
    for (int k = 0; k < aw_q.size(); k++) if (aw_q[k] !== BASE + 32'(k * 8 * BL)) bad_addr++;
    for (int i = 0; i < NW; i++) if (mem[i] !== FILL) bad_mem++;
    checks++; if (!got_done) begin errors++; $display("FAIL %s done: not reached within budget", tag); end
    checks++; if (aw_q.size() !== NB) begin errors++; $display("FAIL %s bursts: got %0d exp %0d", tag, aw_q.size(), NB); end
    checks++; if (bad_addr !== 0) begin errors++; $display("FAIL %s awaddr: %0d wrong addresses", tag, bad_addr); end
    checks++; if (beats !== NW) begin errors++; $display("FAIL %s beats: got %0d exp %0d", tag, beats, NW); end
    checks++; if (bad_mem !== 0) begin errors++; $display("FAIL %s memory: %0d words not fill data", tag, bad_mem); end
    checks++; if (len_bad + wlast_bad !== 0) begin errors++; $display("FAIL %s payload: awbad=%0d wbad=%0d exp 0", tag, len_bad, wlast_bad); end
    checks++; if (stable_bad + order_bad !== 0) begin errors++; $display("FAIL %s protocol: unstable=%0d order=%0d exp 0", tag, stable_bad, order_bad); end
    checks++; if (post_bad !== 0) begin errors++; $display("FAIL %s done_hold: %0d bad cycles exp 0", tag, post_bad); end
    checks++; if (o_init_error !== exp_err) begin errors++; $display("FAIL %s error: got %0b exp %0b", tag, o_init_error, exp_err); end
  endtask

  task automatic pulse_start;
    @(negedge clk);
    i_start = 1;
  endtask

  task automatic test_reset;
    int n;
    #1;
    checks++; if ({o_awvalid, o_wvalid, o_wlast, o_bready, o_busy, o_init_done, o_init_error} !== 7'b0)
      begin errors++; $display("FAIL reset_outputs: got %b exp 0", {o_awvalid, o_wvalid, o_wlast, o_bready, o_busy, o_init_done, o_init_error}); end
    checks++; if (o_awaddr !== BASE) begin errors++; $display("FAIL reset_awaddr: got %h exp %h", o_awaddr, BASE); end
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    n = 0;
    while (o_awvalid !== 1'b1 && n < 10) begin @(posedge clk); n++; #1; end
    checks++; if (n !== 2) begin errors++; $display("FAIL auto_start_latency: got %0d edges exp 2", n); end
  endtask

  task automatic test_auto_fill;
    bit r;
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    run_fill(0, -1, -1, 0, -1, r);
    check_fill("auto", 0);
    checks++; if (done_cyc - first_cyc !== 48) begin errors++; $display("FAIL auto_timing: got %0d cycles exp 48", done_cyc - first_cyc); end
  endtask

  task automatic test_stall;
    bit r;
    pulse_start;
    run_fill(1, -1, -1, 0, -1, r);
    check_fill("stall", 0);
  endtask

  task automatic test_bresp_error;
    bit r;
    pulse_start;
    run_fill(1, 3, -1, 0, -1, r);
    check_fill("bresp", 1);
    @(negedge clk); i_start = 1;
    @(negedge clk); i_start = 0;
    checks++; if ({o_init_done, o_init_error, o_busy, o_awvalid} !== 4'b0011)
      begin errors++; $display("FAIL restart_flags: got %b exp 0011", {o_init_done, o_init_error, o_busy, o_awvalid}); end
    run_fill(0, -1, -1, 0, -1, r);
    check_fill("rerun", 0);
  endtask

  task automatic test_bad_id;
    bit r;
    pulse_start;
    run_fill(1, -1, 5, 0, -1, r);
    check_fill("bid", 1);
  endtask

  task automatic test_start_ignored;
    bit r;
    pulse_start;
    run_fill(0, -1, -1, 1, -1, r);
    check_fill("busy_start", 0);
    checks++; if (done_cyc - first_cyc !== 48) begin errors++; $display("FAIL busy_start_timing: got %0d exp 48", done_cyc - first_cyc); end
  endtask

  task automatic test_reset_mid_burst;
    bit r;
    pulse_start;
    run_fill(1, -1, -1, 0, 2, r);
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL midrst_reach: got %0b exp 1", r); end
    checks++; if ({o_awvalid, o_wvalid, o_wlast, o_bready, o_busy, o_init_done, o_init_error} !== 7'b0)
      begin errors++; $display("FAIL midrst_outputs: got %b exp 0", {o_awvalid, o_wvalid, o_wlast, o_bready, o_busy, o_init_done, o_init_error}); end
    checks++; if (o_awaddr !== BASE) begin errors++; $display("FAIL midrst_awaddr: got %h exp %h", o_awaddr, BASE); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    run_fill(1, -1, -1, 0, -1, r);
    check_fill("after_rst", 0);
  endtask

  initial begin
    test_reset;
    test_auto_fill;
    test_stall;
    test_bresp_error;
    test_bad_id;
    test_start_ignored;
    test_reset_mid_burst;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
